// File: rtl/divu_pkg.sv
// rtl/divu_pkg.sv - shared types and constants for the 4-bit sequential divider
package divu_pkg;

   localparam int DIV_W     = 4;
   localparam int DIV_ITERS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/subtr_4.sv
// rtl/subtr_4.sv - combinational 4-bit subtractor, d = a - b, bo = 1 when no borrow
module subtr_4
   import divu_pkg::*;
(
   input  logic [DIV_W-1:0] a,
   input  logic [DIV_W-1:0] b,
   output logic [DIV_W-1:0] d,
   output logic             bo
);

   logic [DIV_W:0] w_diff;

   assign w_diff = {1'b0, a} - {1'b0, b};
   assign d      = w_diff[DIV_W-1:0];
   assign bo     = ~w_diff[DIV_W];

endmodule

// File: rtl/divu_4_seq.sv
// rtl/divu_4_seq.sv - sequential 4-bit unsigned restoring divider, one quotient bit per cycle
module divu_4_seq
   import divu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] dvd,
   input  logic [DIV_W-1:0] dvs,
   output logic [DIV_W-1:0] q,
   output logic [DIV_W-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   div_state_t       r_state;
   div_state_t       w_next;
   logic [1:0]       r_cnt;
   logic [DIV_W-1:0] r_rem;
   logic [DIV_W-1:0] r_sh;
   logic [DIV_W-1:0] r_dvs;
   logic [DIV_W-1:0] r_q;
   logic [DIV_W-1:0] r_r;
   logic             r_busy;
   logic             r_done;
   logic             r_dz;

   logic [DIV_W-1:0] w_t;
   logic [DIV_W-1:0] w_d;
   logic             w_bo;
   logic             w_ge;
   logic [DIV_W-1:0] w_rem_nx;
   logic [DIV_W-1:0] w_sh_nx;
   logic             w_accept;
   logic             w_last;

   // The partial remainder's MSB is the fifth bit of the trial value; when set,
   // the subtraction always succeeds and the low four bits of d are still exact.
   assign w_t      = {r_rem[DIV_W-2:0], r_sh[DIV_W-1]};
   assign w_ge     = r_rem[DIV_W-1] | w_bo;
   assign w_rem_nx = w_ge ? w_d : w_t;
   assign w_sh_nx  = {r_sh[DIV_W-2:0], w_ge};
   assign w_accept = start && (r_state != RUN);
   assign w_last   = (r_cnt == 2'(DIV_ITERS - 1));

   subtr_4 u_subtr (
      .a  (w_t),
      .b  (r_dvs),
      .d  (w_d),
      .bo (w_bo)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (start)
               w_next = (dvs == '0) ? DONE : RUN;
            else
               w_next = IDLE;
         end
         RUN: begin
            if (w_last)
               w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_sh    <= '0;
         r_dvs   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         if (w_accept) begin
            r_dvs <= dvs;
            r_sh  <= dvd;
            r_rem <= '0;
            r_cnt <= '0;
            if (dvs == '0) begin
               r_q    <= '1;
               r_r    <= dvd;
               r_dz   <= 1'b1;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end else begin
               r_busy <= 1'b1;
            end
         end else if (r_state == RUN) begin
            r_rem <= w_rem_nx;
            r_sh  <= w_sh_nx;
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
               r_q    <= w_sh_nx;
               r_r    <= w_rem_nx;
               r_dz   <= 1'b0;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign q    = r_q;
   assign r    = r_r;
   assign busy = r_busy;
   assign done = r_done;
   assign dz   = r_dz;

endmodule

// File: tb/tb_divu_4_seq.sv
// tb/tb_divu_4_seq.sv - self-checking bench for divu_4_seq with an expected-result queue
module tb_divu_4_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] dvd;
   logic [3:0] dvs;
   logic [3:0] q;
   logic [3:0] r;
   logic       busy;
   logic       done;
   logic       dz;

   typedef struct {
      logic [3:0] q;
      logic [3:0] r;
      logic       dz;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   divu_4_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .dvd   (dvd),
      .dvs   (dvs),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .done  (done),
      .dz    (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      if (b == 4'd0) begin
         e.q  = 4'hF;
         e.r  = a;
         e.dz = 1'b1;
      end else begin
         e.q  = 4'(int'(a) / int'(b));
         e.r  = 4'(int'(a) % int'(b));
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Drives start for one edge; when push is set the expected result is queued.
   task automatic launch(input logic [3:0] a, input logic [3:0] b, input bit push);
      start = 1'b1;
      dvd   = a;
      dvs   = b;
      if (push) sb.push_back(model(a, b));
      step();
      start = 1'b0;
   endtask

   // Waits (bounded) for done; returns cycles waited and whether it arrived.
   task automatic wait_done(output int cycles, output bit ok);
      cycles = 0;
      while (!done && cycles < 20) begin
         step();
         cycles++;
      end
      ok = done;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      dvd   = '0;
      dvs   = '0;
      step();
      step();
      rst = 1'b0;
      n_tests++;
      if ({q, r, busy, done, dz} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0", q, r, busy, done, dz);
      end
   endtask

   task automatic test_basic();
      int   busy_cnt;
      int   cyc;
      bit   overlap;
      exp_t e;
      launch(4'd13, 4'd3, 1'b1);
      busy_cnt = 0;
      cyc      = 0;
      overlap  = 1'b0;
      while (!done && cyc < 20) begin
         if (busy) busy_cnt++;
         step();
         cyc++;
         if (busy && done) overlap = 1'b1;
      end
      n_tests++;
      if (!done || cyc != 4) begin
         n_fail++;
         $display("FAIL basic_latency: got done=%b after %0d cycles, want done after 4", done, cyc);
      end
      n_tests++;
      if (busy_cnt != 4 || overlap) begin
         n_fail++;
         $display("FAIL basic_busy: got busy for %0d cycles overlap=%b, want 4 cycles no overlap", busy_cnt, overlap);
      end
      e = sb.pop_front();
      n_tests++;
      if (q !== e.q || r !== e.r || dz !== e.dz) begin
         n_fail++;
         $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b", q, r, dz, e.q, e.r, e.dz);
      end
      step();
      n_tests++;
      if (done !== 1'b0 || q !== e.q || r !== e.r) begin
         n_fail++;
         $display("FAIL basic_done_pulse: got done=%b q=%0d r=%0d, want done=0 q=%0d r=%0d", done, q, r, e.q, e.r);
      end
   endtask

   task automatic test_values();
      logic [3:0] a_tab [3] = '{4'd15, 4'd7, 4'd15};
      logic [3:0] b_tab [3] = '{4'd1, 4'd9, 4'd15};
      int   cyc;
      bit   ok;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         launch(a_tab[i], b_tab[i], 1'b1);
         wait_done(cyc, ok);
         e = sb.pop_front();
         n_tests++;
         if (!ok || q !== e.q || r !== e.r || dz !== e.dz) begin
            n_fail++;
            $display("FAIL values_%0d_%0d: got done=%b q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                     a_tab[i], b_tab[i], ok, q, r, dz, e.q, e.r, e.dz);
         end
         step();
      end
   endtask

   task automatic test_div_zero();
      exp_t e;
      launch(4'd9, 4'd0, 1'b1);
      e = sb.pop_front();
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || q !== e.q || r !== e.r || dz !== e.dz) begin
         n_fail++;
         $display("FAIL div_zero: got done=%b busy=%b q=%0d r=%0d dz=%b, want done=1 busy=0 q=%0d r=%0d dz=%b",
                  done, busy, q, r, dz, e.q, e.r, e.dz);
      end
      step();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || dz !== 1'b1) begin
         n_fail++;
         $display("FAIL div_zero_after: got done=%b busy=%b dz=%b, want done=0 busy=0 dz=1", done, busy, dz);
      end
   endtask

   task automatic test_start_ignored();
      int   cyc;
      bit   ok;
      exp_t e;
      launch(4'd12, 4'd5, 1'b1);
      step();
      launch(4'd14, 4'd2, 1'b0);
      wait_done(cyc, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || q !== e.q || r !== e.r || dz !== e.dz) begin
         n_fail++;
         $display("FAIL start_ignored: got done=%b q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                  ok, q, r, dz, e.q, e.r, e.dz);
      end
      step();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_ignored_idle: got done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      bit   ok;
      exp_t e;
      launch(4'd11, 4'd4, 1'b1);
      wait_done(cyc, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || q !== e.q || r !== e.r || dz !== e.dz) begin
         n_fail++;
         $display("FAIL b2b_first: got done=%b q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                  ok, q, r, dz, e.q, e.r, e.dz);
      end
      launch(4'd6, 4'd3, 1'b1);
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== e.q || r !== e.r) begin
         n_fail++;
         $display("FAIL b2b_relaunch: got busy=%b done=%b q=%0d r=%0d, want busy=1 done=0 q=%0d r=%0d",
                  busy, done, q, r, e.q, e.r);
      end
      wait_done(cyc, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || cyc != 4 || q !== e.q || r !== e.r || dz !== e.dz) begin
         n_fail++;
         $display("FAIL b2b_second: got done=%b cycles=%0d q=%0d r=%0d dz=%b, want cycles=4 q=%0d r=%0d dz=%b",
                  ok, cyc, q, r, dz, e.q, e.r, e.dz);
      end
      step();
   endtask

   task automatic test_reset_mid_run();
      bit saw_done;
      launch(4'd14, 4'd3, 1'b0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if ({q, r, busy, done, dz} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_mid_run: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0", q, r, busy, done, dz);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done || busy) saw_done = 1'b1;
      end
      n_tests++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL reset_mid_run_quiet: got activity after reset=1, want 0");
      end
   endtask

   task automatic test_sweep();
      int   cyc;
      bit   ok;
      exp_t e;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            launch(4'(a), 4'(b), 1'b1);
            wait_done(cyc, ok);
            e = sb.pop_front();
            n_tests++;
            if (!ok || q !== e.q || r !== e.r || dz !== e.dz) begin
               n_fail++;
               $display("FAIL sweep_%0d_%0d: got done=%b q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                        a, b, ok, q, r, dz, e.q, e.r, e.dz);
            end
            step();
         end
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      dvd   = '0;
      dvs   = '0;
      test_reset();
      test_basic();
      test_values();
      test_div_zero();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/divu_4_seq.md
# divu_4_seq

Sequential 4-bit unsigned restoring divider that consumes the team's combinational 4-bit subtractor `subtr_4` as its trial-subtraction stage. It produces one quotient bit per clock over four iterations. A start/busy/done handshake lets a controller launch a division and collect quotient, remainder and a divide-by-zero flag. It sits downstream of `subtr_4` in the datapath: its partial remainder and divisor drive the subtractor each cycle, and it consumes `d`/`bo`.

## Interface
- No parameters. Width is fixed at 4 to match `subtr_4`.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled on rising edge
- dvd  input  4  dividend; captured when start is accepted
- dvs  input  4  divisor; captured when start is accepted
- q  output  4  quotient; registered
- r  output  4  remainder; registered
- busy  output  1  division in progress
- done  output  1  one-cycle pulse; q/r/dz valid
- dz  output  1  divide-by-zero flag, valid with done

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset** (rst high at an edge):
  - state goes to IDLE.
  - q=0, r=0, busy=0, done=0, dz=0.
  - Internal rem/shift/count registers are cleared.
- **Start acceptance:**
  - start is accepted only in IDLE or DONE.
  - On accept, capture dvs into dvs_r and dvd into a shift register sh. Clear rem=0 and cnt=0.
  - If dvs==0: next state is DONE with q=4'hF, r=dvd, dz=1. There is no RUN phase.
  - Otherwise: next state is RUN, busy=1.
- **Start ignored:** start has no effect in RUN. Captured operands and the iteration are undisturbed.
- **RUN iteration** (one per cycle, cnt=0..3):
  - t = {rem[2:0], sh[3]}; msb = rem[3].
  - subtr_4 computes t − dvs_r, giving d and bo. bo=1 means t ≥ dvs_r (no borrow).
  - ge = msb | bo. When msb=1 the true 5-bit value exceeds any 4-bit divisor, and the low 4 bits of d are still exact.
  - If ge: rem ← d. Otherwise rem ← t.
  - sh ← {sh[2:0], ge}. The dividend shifts out of the MSB while quotient bits shift into the LSB.
  - cnt increments. When cnt==3, next state is DONE.
- **Entering DONE from RUN:**
  - q ← final sh, r ← final rem, dz ← 0.
  - busy ← 0, done ← 1.
- **In DONE:**
  - done is high for exactly one cycle.
  - The next state is IDLE, or RUN/DONE if start is high in that cycle (back-to-back launch).
- **Output hold:** q, r and dz hold their values after done until the next completion or reset. They do not change during RUN.
- **Results:** for dvs≠0, q = dvd / dvs and r = dvd % dvs (unsigned integer), with r < dvs always.

## Timing
- Start accepted at edge E0 (dvs≠0):
  - busy=1 from E0 through E4.
  - Iterations occur at edges E1..E4.
  - After E4: done=1, busy=0, q/r valid.
  - After E5: done=0, unless a new start was accepted at E5.
- Divide-by-zero: done=1 and dz=1 after E0 (1-cycle latency). busy stays 0.
- Throughput: one division per 5 cycles with back-to-back start.
- busy and done are never high in the same cycle.
- Reset mid-RUN: the next cycle is IDLE with all outputs 0. No done pulse is produced, and the aborted operands are discarded.
- rst has priority over start in the same cycle.
- The subtractor path is purely combinational within one cycle. There are no multicycle paths.

## Structure
- Shared package `divu_pkg` holds:
  - `div_state_t` enum: IDLE, RUN, DONE.
  - constant `DIV_W = 4`.
  - constant `DIV_ITERS = 4`.
- One sub-module instance, `subtr_4`. Its inputs are a=t, b=dvs_r. Its output d is the trial difference; output bo is the no-borrow flag.
- Everything else lives in the top module: FSM, cnt[1:0], rem[3:0], sh[3:0], dvs_r[3:0], output registers.

## Test plan
- dvd=13, dvs=3, start at E0 -> done after E4 with q=4, r=1, dz=0. busy high exactly 4 cycles.
- dvd=15, dvs=1 -> q=15, r=0. Then dvd=7, dvs=9 -> q=0, r=7. Then dvd=15, dvs=15 -> q=1, r=0.
- dvd=9, dvs=0 -> done and dz one cycle after the start edge, q=4'hF, r=9, busy never high.
- Start 12/5, then pulse start with 14/2 at E2 -> second start ignored; result q=2, r=2.
- Start 11/4 and hold start high during the DONE cycle with 6/3 -> first result q=2, r=3. Second done five cycles later with q=2, r=0.
- Start 14/3, assert rst at E2 -> next cycle IDLE, q=r=busy=done=dz=0, no done pulse. Exhaustive sweep of all 256 operand pairs matches `/` and `%`, with dz only for dvs=0.
